motor_pwm_driver: RTL and testbench
===================================

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 Parameter DEAD_CYCLES, default 8, dead-time length in clk cycles on direction reversal; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd  input  4  direction command: [3]=A forward, [2]=A reverse, [1]=B forward, [0]=B reverse.
REQ-005 duty  input  8  PWM duty for both channels, in 1/256 units.
REQ-006 out  output  4  H-bridge drive, same bit order as cmd.
REQ-007 fault  output  1  sticky illegal-command flag.
REQ-008 dead  output  2  [1]=channel A in dead time, [0]=channel B in dead time.

Function
REQ-009 Channels A and B SHALL be identical and independent, each decoding its cmd bit pair as 10=FWD, 01=REV, 00=STOP, 11=ILLEGAL.
REQ-010 ILLEGAL SHALL be treated as STOP and SHALL set fault on the same edge; fault stays 1 until reset.
REQ-011 Each channel SHALL have states IDLE, FWD, REV, DEAD.
REQ-012 IDLE: STOP stays IDLE; FWD/REV command enters FWD/REV on the sampling edge.
REQ-013 FWD (REV): same direction stays; STOP/ILLEGAL goes to IDLE; opposite direction goes to DEAD with dead counter loaded to DEAD_CYCLES-1.
REQ-014 DEAD: counter decrements each cycle; at counter 0 the next state SHALL be decoded from the cmd then present (IDLE, FWD or REV); STOP during DEAD does not shorten it.
REQ-015 An 8-bit free-running pwm_cnt SHALL increment every cycle and wrap 255->0; PWM period is 256 cycles.
REQ-016 duty SHALL be captured into duty_q only on the edge where pwm_cnt wraps 255->0.
REQ-017 pwm_on = (pwm_cnt < effective duty); duty 0 gives never-on, duty 255 gives 255 of 256 cycles on.
REQ-018 out SHALL be registered: forward pin = (state==FWD && pwm_on), reverse pin = (state==REV && pwm_on), evaluated on post-edge values; latency cmd->out is one edge.
REQ-019 IDLE and DEAD SHALL drive both pins of the channel 0 (coast).
REQ-020 Both pins of one channel SHALL never be 1 in the same cycle, under any input sequence.
REQ-021 dead bit SHALL be 1 exactly while its channel is in DEAD.

Reset
REQ-022 While reset is 1: out=0, dead=0, fault=0, both channels IDLE, pwm_cnt=0, duty_q=0, dead counters 0, ramp registers 0.
REQ-023 Reset asserted mid-operation (including during DEAD) SHALL force REQ-022 values immediately, without waiting for a clock edge.
REQ-024 After deassertion, first edge samples cmd normally; duty takes effect only after the first 255->0 wrap.

Configuration
REQ-025 Macro SOFT_START_EN: when defined, each channel holds a ramp value reset to 0 on entry to FWD/REV from IDLE or DEAD, increased by 16 (saturating at duty_q) at each pwm_cnt wrap; effective duty = min(ramp, duty_q).
REQ-026 Without SOFT_START_EN, effective duty = duty_q; no ramp logic is present.

Verification
REQ-027 duty=128 held, cmd=1000 after reset -> out[3] high exactly 128 of each 256 cycles after first wrap; out[2:0]=0.
REQ-028 Channel A FWD at duty=255, cmd 1000->0100 -> dead[1]=1 and out[3:2]=00 for exactly DEAD_CYCLES (8) cycles, then out[2] pulses; out[3] never 1 concurrently with out[2].
REQ-029 cmd=0011 for one cycle -> out[1:0]=00, fault=1 and stays 1 after cmd=0010, until reset.
REQ-030 duty changed 64->200 at pwm_cnt=10 -> on-time stays 64 until wrap, then 200.
REQ-031 Reset pulsed during DEAD of channel B -> out=0, dead=0, fault=0 immediately; after release cmd=0001 -> REV with no dead time.
REQ-032 SOFT_START_EN defined, duty=64, cmd=1000 from IDLE -> on-time per period 0,16,32,48,64,64... cycles.

Source files
------------

// File: rtl/motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// motor_pwm_driver
//
// Two-channel H-bridge driver. Each channel (A, B) decodes a direction command
// into IDLE / FWD / REV and inserts a fixed dead time on direction reversal.
// A shared 8-bit free-running counter produces PWM. The duty input is sampled
// only at period boundaries, so every period runs at one duty value.
//
// Optional feature (macro SOFT_START_EN): per-channel soft-start ramp. It
// limits the effective duty, starting at 0 on each start of motion and
// rising by 16 every PWM period until it reaches duty_q.
//
// Parameters:
//   DEAD_CYCLES  dead-time length in clk cycles on reversal (1..255)
//
// Ports:
//   clk    in   1  clock, rising edge
//   reset  in   1  asynchronous, active-high reset
//   cmd    in   4  [3]=A fwd, [2]=A rev, [1]=B fwd, [0]=B rev
//   duty   in   8  PWM duty for both channels, 1/256 units
//   out    out  4  H-bridge drive, same bit order as cmd (registered)
//   fault  out  1  sticky flag, set by any 11 (illegal) command pair
//   dead   out  2  [1]=A in dead time, [0]=B in dead time
// -----------------------------------------------------------------------------
module motor_pwm_driver #(
    parameter int unsigned DEAD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cmd,
    input  logic [7:0] duty,
    output logic [3:0] out,
    output logic       fault,
    output logic [1:0] dead
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_REV,
        ST_DEAD
    } state_t;

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    // Illegal (11) decodes as STOP; the fault flag is handled separately.
    function automatic state_t decode(input logic [1:0] pair);
        case (pair)
            2'b10:   decode = ST_FWD;
            2'b01:   decode = ST_REV;
            default: decode = ST_IDLE;
        endcase
    endfunction

    // ---------------------------------------------------------------- PWM base
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0] duty_q, duty_d;
    logic       wrap;

    always_comb begin
        wrap      = (pwm_cnt_q == 8'hFF);
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        duty_d    = wrap ? duty : duty_q;
    end

    // -------------------------------------------------------------- shared out
    logic [3:0] out_q, out_d;
    logic       fault_q, fault_d;
    logic [1:0] illegal;

    assign fault_d = fault_q | (|illegal);

    // NOTE: the reset branch is in the sensitivity list so reset acts without
    // waiting for a clock edge, and outputs clear the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            out_q     <= '0;
            fault_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            out_q     <= out_d;
            fault_q   <= fault_d;
        end
    end

    assign out   = out_q;
    assign fault = fault_q;

    // ---------------------------------------------------------------- channels
    // ch=1 is channel A (cmd[3:2]), ch=0 is channel B (cmd[1:0]).
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        localparam int RB = 2 * ch;
        localparam int FB = 2 * ch + 1;

        state_t     state_q, state_d;
        logic [7:0] dcnt_q, dcnt_d;
        logic [7:0] eff_duty_d;
        logic [1:0] pair;
        state_t     req;
        logic       pwm_on_d;

        assign pair       = cmd[RB +: 2];
        assign req        = decode(pair);
        assign illegal[ch] = &pair;

        always_comb begin
            // NOTE: every output of this block gets a default first, so no
            // path leaves a value unassigned and no latch is inferred.
            state_d = state_q;
            dcnt_d  = dcnt_q;
            unique case (state_q)
                ST_IDLE: state_d = req;
                ST_FWD: begin
                    if (req == ST_REV) begin
                        state_d = ST_DEAD;
                        dcnt_d  = DEAD_LOAD;
                    end else if (req == ST_IDLE) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REV: begin
                    if (req == ST_FWD) begin
                        state_d = ST_DEAD;
                        dcnt_d  = DEAD_LOAD;
                    end else if (req == ST_IDLE) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    // Full dead time always elapses; cmd is only looked at
                    // once the counter has reached zero.
                    if (dcnt_q == 8'd0) state_d = req;
                    else                dcnt_d  = dcnt_q - 8'd1;
                end
            endcase
        end

`ifdef SOFT_START_EN
        logic [7:0] ramp_q, ramp_d;
        logic [8:0] ramp_inc;
        logic       starting;

        always_comb begin
            ramp_d   = ramp_q;
            ramp_inc = {1'b0, ramp_q} + 9'd16;
            starting = ((state_d == ST_FWD) || (state_d == ST_REV)) &&
                       ((state_q == ST_IDLE) || (state_q == ST_DEAD));
            if (starting) begin
                ramp_d = '0;
            end else if (wrap) begin
                ramp_d = (ramp_inc > {1'b0, duty_d}) ? duty_d : ramp_inc[7:0];
            end
            eff_duty_d = (ramp_d < duty_d) ? ramp_d : duty_d;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) ramp_q <= '0;
            else       ramp_q <= ramp_d;
        end
`else
        assign eff_duty_d = duty_d;
`endif

        // Output is computed from post-edge state/counter/duty so a command
        // reaches the pins on the same edge that changes the state.
        assign pwm_on_d  = (pwm_cnt_d < eff_duty_d);
        assign out_d[FB] = (state_d == ST_FWD) && pwm_on_d;
        assign out_d[RB] = (state_d == ST_REV) && pwm_on_d;
        assign dead[ch]  = (state_q == ST_DEAD);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                dcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_motor_pwm_driver
//
// Directed bench for motor_pwm_driver (default build, DEAD_CYCLES = 8).
// Inputs change and outputs are sampled on the falling clock edge. tb_cnt
// counts rising edges since reset release, so (tb_cnt % 256) is the PWM phase
// the DUT should be in after each edge.
// -----------------------------------------------------------------------------
module tb_motor_pwm_driver;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cmd   = 4'b0000;
    logic [7:0] duty  = 8'd0;
    logic [3:0] out;
    logic       fault;
    logic [1:0] dead;

    int tests_run    = 0;
    int tests_failed = 0;
    int tb_cnt;
    int overlap_cnt  = 0;

    motor_pwm_driver #(.DEAD_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd),
        .duty  (duty),
        .out   (out),
        .fault (fault),
        .dead  (dead)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= tb_cnt + 1;
    end

    // Shoot-through watch across the whole run.
    always @(negedge clk) begin
        if ((out[3] && out[2]) || (out[1] && out[0])) overlap_cnt++;
    end

    // Assert reset mid-cycle, check reset values, release on a falling edge
    // with the given inputs applied.
    task automatic do_reset(input logic [3:0] c, input logic [7:0] d);
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (out !== 4'b0000 || dead !== 2'b00 || fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: out=%b dead=%b fault=%b, want 0000 00 0", out, dead, fault);
        end
        cmd  = c;
        duty = d;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (out !== 4'b0000 || dead !== 2'b00 || fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held: out=%b dead=%b fault=%b, want 0000 00 0", out, dead, fault);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(4'b0000, 8'd0);
        repeat (4) @(negedge clk);
        tests_run++;
        if (out !== 4'b0000 || dead !== 2'b00 || fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: out=%b dead=%b fault=%b, want 0000 00 0", out, dead, fault);
        end
    endtask

    // duty=128 forward on A: nothing before first wrap, then 128/256 on.
    task automatic test_pwm_half();
        int pre_err, low_err, on_cnt;
        logic first_hi;
        do_reset(4'b1000, 8'd128);
        pre_err = 0;
        repeat (255) begin
            @(negedge clk);
            if (out !== 4'b0000) pre_err++;
        end
        tests_run++;
        if (pre_err != 0) begin
            tests_failed++;
            $display("FAIL pwm_pre_wrap: %0d active samples, want 0", pre_err);
        end
        for (int p = 0; p < 2; p++) begin
            on_cnt = 0;
            low_err = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (i == 0) first_hi = out[3];
                if (out[3] === 1'b1) on_cnt++;
                if (out[2:0] !== 3'b000) low_err++;
                if (out[3] !== (i < 128)) low_err++;
            end
            tests_run++;
            if (on_cnt != 128) begin
                tests_failed++;
                $display("FAIL pwm_half_on_time[%0d]: got %0d, want 128", p, on_cnt);
            end
            tests_run++;
            if (low_err != 0 || first_hi !== 1'b1) begin
                tests_failed++;
                $display("FAIL pwm_half_shape[%0d]: %0d bad samples, first=%b want 0 and 1", p, low_err, first_hi);
            end
        end
    endtask

    // Reversal on A at duty 255, then reversal with STOP during dead time.
    task automatic test_dead_time();
        int dead_n, first_rev, bad;
        do_reset(4'b1000, 8'd255);
        repeat (300) @(negedge clk);
        tests_run++;
        if (out !== 4'b1000) begin
            tests_failed++;
            $display("FAIL fwd_full_duty: out=%b, want 1000", out);
        end
        cmd = 4'b0100;
        dead_n = 0; first_rev = 0; bad = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (dead[1] === 1'b1) begin
                dead_n++;
                if (out[3:2] !== 2'b00) bad++;
            end
            if (dead[0] !== 1'b0) bad++;
            if (out[2] === 1'b1 && first_rev == 0) first_rev = i;
        end
        tests_run++;
        if (dead_n != 8) begin
            tests_failed++;
            $display("FAIL dead_len: got %0d cycles, want 8", dead_n);
        end
        tests_run++;
        if (first_rev != 9) begin
            tests_failed++;
            $display("FAIL rev_after_dead: first out[2] at sample %0d, want 9", first_rev);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL dead_outputs: %0d bad samples, want 0", bad);
        end
        // REV -> FWD, then STOP during dead time: full 8 cycles, then coast.
        cmd = 4'b1000;
        dead_n = 0; bad = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 2) cmd = 4'b0000;
            if (dead[1] === 1'b1) dead_n++;
            if (out !== 4'b0000) bad++;
        end
        tests_run++;
        if (dead_n != 8 || bad != 0) begin
            tests_failed++;
            $display("FAIL dead_stop: dead=%0d bad=%0d, want 8 and 0", dead_n, bad);
        end
        tests_run++;
        if (dead !== 2'b00) begin
            tests_failed++;
            $display("FAIL dead_exit_idle: dead=%b, want 00", dead);
        end
    endtask

    // Illegal command on B: coast, sticky fault until reset.
    task automatic test_fault();
        do_reset(4'b0011, 8'd255);
        @(negedge clk);
        tests_run++;
        if (fault !== 1'b1 || out[1:0] !== 2'b00) begin
            tests_failed++;
            $display("FAIL fault_set: fault=%b out=%b, want 1 xx00", fault, out);
        end
        cmd = 4'b0010;
        repeat (260) @(negedge clk);
        tests_run++;
        if (fault !== 1'b1 || out !== 4'b0010) begin
            tests_failed++;
            $display("FAIL fault_sticky: fault=%b out=%b, want 1 0010", fault, out);
        end
        do_reset(4'b0000, 8'd0);
        @(negedge clk);
        tests_run++;
        if (fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_cleared: fault=%b, want 0", fault);
        end
    endtask

    // Duty 64 -> 200 mid-period: takes effect only at the next wrap.
    task automatic test_duty_change();
        int on_cnt;
        do_reset(4'b1000, 8'd64);
        repeat (255) @(negedge clk);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (out[3] === 1'b1) on_cnt++;
            if (tb_cnt == 266) duty = 8'd200;
        end
        tests_run++;
        if (on_cnt != 64) begin
            tests_failed++;
            $display("FAIL duty_old_period: on=%0d, want 64", on_cnt);
        end
        on_cnt = 0;
        repeat (256) begin
            @(negedge clk);
            if (out[3] === 1'b1) on_cnt++;
        end
        tests_run++;
        if (on_cnt != 200) begin
            tests_failed++;
            $display("FAIL duty_new_period: on=%0d, want 200", on_cnt);
        end
    endtask

    // Reset during B dead time clears everything at once; no dead time after.
    task automatic test_reset_in_dead();
        int dead_seen;
        do_reset(4'b1100, 8'd255);
        @(negedge clk);
        cmd = 4'b0010;
        repeat (270) @(negedge clk);
        tests_run++;
        if (out !== 4'b0010 || fault !== 1'b1) begin
            tests_failed++;
            $display("FAIL b_fwd: out=%b fault=%b, want 0010 1", out, fault);
        end
        cmd = 4'b0001;
        repeat (3) @(negedge clk);
        tests_run++;
        if (dead !== 2'b01) begin
            tests_failed++;
            $display("FAIL b_in_dead: dead=%b, want 01", dead);
        end
        do_reset(4'b0001, 8'd255);
        dead_seen = 0;
        repeat (258) begin
            @(negedge clk);
            if (dead !== 2'b00) dead_seen++;
        end
        tests_run++;
        if (dead_seen != 0 || out !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rev_after_reset: dead samples=%0d out=%b, want 0 0001", dead_seen, out);
        end
    endtask

    initial begin
        test_reset();
        test_pwm_half();
        test_dead_time();
        test_fault();
        test_duty_change();
        test_reset_in_dead();
        tests_run++;
        if (overlap_cnt != 0) begin
            tests_failed++;
            $display("FAIL shoot_through: %0d samples with both pins high, want 0", overlap_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
